// File: rtl/uart_program_loader_if.sv
// ITCM write port driven by the program loader.
// Handshake: itcm_we is a one-cycle valid strobe; the ITCM is always ready, so
// every cycle with itcm_we=1 is one accepted write of itcm_wdata at itcm_addr.
interface uart_program_loader_if #(
   parameter int ADDR_WIDTH = 12
) ();
   logic                  itcm_we;
   logic [ADDR_WIDTH-1:0] itcm_addr;
   logic [31:0]           itcm_wdata;

   modport master (output itcm_we, output itcm_addr, output itcm_wdata);
   modport slave  (input  itcm_we, input  itcm_addr, input  itcm_wdata);
endinterface

// File: rtl/uart_program_loader.sv
// Boot loader: receives an 8N1 UART program image (16-bit LE word count, then
// LE 32-bit words), writes each word to the ITCM and releases core_hold once
// the whole image has been written.
module uart_program_loader #(
   parameter int CLKS_PER_BIT = 1476,
   parameter int ADDR_WIDTH   = 12,
   parameter int MAX_WORDS    = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  uart_rx,
   uart_program_loader_if.master itcm,
   output logic                  core_hold,
   output logic                  load_done,
   output logic                  frame_error,
   output logic [1:0]            dbg_rx_state,
   output logic [2:0]            dbg_ld_state
);
   localparam int CW   = $clog2(CLKS_PER_BIT + 1);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int WW   = $clog2(MAX_WORDS + 1);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   // L_LAST is the single cycle in which the final itcm_we is visible, so that
   // load_done/core_hold change one cycle after the last write.
   localparam logic [2:0] L_CNT_LO = 3'd0;
   localparam logic [2:0] L_CNT_HI = 3'd1;
   localparam logic [2:0] L_DATA   = 3'd2;
   localparam logic [2:0] L_LAST   = 3'd3;
   localparam logic [2:0] L_DONE   = 3'd4;

   logic          rx_meta, rx_sync, rx_prev;
   logic [1:0]    rx_state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    rx_shift;
   logic          byte_valid, frame_pulse;

   logic [2:0]    ld_state;
   logic [7:0]    n_lo;
   logic [WW-1:0] n_eff, word_idx;
   logic [1:0]    byte_idx;
   logic [23:0]   word_lo;
   logic [15:0]   n_full;
   logic [WW-1:0] n_clamp;

   assign dbg_rx_state = rx_state;
   assign dbg_ld_state = ld_state;

   // Word count as it stands once the high byte arrives, clamped to ITCM size.
   always_comb begin
      n_full  = {rx_shift, n_lo};
      n_clamp = (32'(n_full) > MAX_WORDS) ? WW'(MAX_WORDS) : WW'(n_full);
   end

   // Two-flop synchronizer plus previous-sample flop for falling-edge detect.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // UART receiver: mid-bit sampling, one-cycle byte_valid / frame_pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state    <= RX_IDLE;
         clk_cnt     <= '0;
         bit_idx     <= '0;
         rx_shift    <= '0;
         byte_valid  <= 1'b0;
         frame_pulse <= 1'b0;
      end else begin
         byte_valid  <= 1'b0;
         frame_pulse <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               clk_cnt <= '0;
               if (rx_prev && !rx_sync) rx_state <= RX_START;
            end
            RX_START: begin
               if (clk_cnt == CW'(HALF - 1)) begin
                  clk_cnt  <= '0;
                  bit_idx  <= '0;
                  rx_state <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                  clk_cnt  <= '0;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  if (bit_idx == 3'd7) rx_state <= RX_STOP;
                  else                 bit_idx  <= bit_idx + 1'b1;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: begin
               if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                  clk_cnt     <= '0;
                  byte_valid  <= rx_sync;
                  frame_pulse <= !rx_sync;
                  rx_state    <= RX_IDLE;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // Loader: word count, word assembly, ITCM writes and core release.
   always_ff @(posedge clk) begin
      if (rst) begin
         ld_state        <= L_CNT_LO;
         n_lo            <= '0;
         n_eff           <= '0;
         word_idx        <= '0;
         byte_idx        <= '0;
         word_lo         <= '0;
         itcm.itcm_we    <= 1'b0;
         itcm.itcm_addr  <= '0;
         itcm.itcm_wdata <= '0;
         core_hold       <= 1'b1;
         load_done       <= 1'b0;
         frame_error     <= 1'b0;
      end else begin
         itcm.itcm_we <= 1'b0;
         if (frame_pulse) frame_error <= 1'b1;
         if (ld_state == L_LAST) begin
            ld_state  <= L_DONE;
            core_hold <= 1'b0;
            load_done <= 1'b1;
         end else if (frame_pulse) begin
            // A corrupted byte invalidates the whole image unless already done.
            if (ld_state != L_DONE) begin
               ld_state <= L_CNT_LO;
               word_idx <= '0;
               byte_idx <= '0;
            end
         end else if (byte_valid) begin
            case (ld_state)
               L_CNT_LO: begin
                  n_lo     <= rx_shift;
                  ld_state <= L_CNT_HI;
               end
               L_CNT_HI: begin
                  n_eff <= n_clamp;
                  if (n_clamp == '0) begin
                     ld_state  <= L_DONE;
                     core_hold <= 1'b0;
                     load_done <= 1'b1;
                  end else begin
                     ld_state <= L_DATA;
                  end
               end
               L_DATA: begin
                  case (byte_idx)
                     2'd0: word_lo[7:0]   <= rx_shift;
                     2'd1: word_lo[15:8]  <= rx_shift;
                     2'd2: word_lo[23:16] <= rx_shift;
                     default: begin
                        itcm.itcm_we    <= 1'b1;
                        itcm.itcm_wdata <= {rx_shift, word_lo};
                        itcm.itcm_addr  <= ADDR_WIDTH'({word_idx, 2'b00});
                        word_idx        <= word_idx + 1'b1;
                        if (word_idx == n_eff - 1'b1) ld_state <= L_LAST;
                     end
                  endcase
                  byte_idx <= byte_idx + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end
endmodule
